// File: rtl/nf10_axis_port_tx_filter.sv
// ---------------------------------------------------------------------------
// nf10_axis_port_tx_filter
//
// Purpose: transmit-side port filter between the switch fabric and one 10G
// interface. Each packet is judged on its first beat: if the destination-port
// byte of tuser (bits [31:24]) hits C_PORT_MASK, the whole packet is queued
// into a small output FIFO and forwarded; otherwise every beat of it is
// accepted and thrown away. Optional forwarded/dropped packet counters.
//
// Optional feature macro: NF10_TX_FILTER_STATS_EN
//   defined   -> pkt_fwd_cnt / pkt_drop_cnt count packets (wrap at 2^32)
//   undefined -> both counter ports are tied to zero, no counter flops
//
// Ports:
//   axi_aclk         in   single rising-edge clock
//   axi_resetn       in   asynchronous active-low reset
//   s_axis_t*        in   switch-side stream (tdata/tstrb/tuser/tvalid/tlast)
//   s_axis_tready    out  back-pressure to the switch
//   m_axis_t*        out  stream towards the 10G interface slave port
//   m_axis_tready    in   back-pressure from the 10G interface
//   pkt_fwd_cnt      out  32-bit forwarded-packet count
//   pkt_drop_cnt     out  32-bit dropped-packet count
// ---------------------------------------------------------------------------
module nf10_axis_port_tx_filter #(
  parameter int         C_AXIS_DATA_WIDTH  = 256,
  parameter int         C_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0] C_PORT_MASK        = 8'h04,
  parameter int         C_FIFO_DEPTH       = 16
) (
  input  logic                            axi_aclk,
  input  logic                            axi_resetn,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,

  output logic [31:0]                     pkt_fwd_cnt,
  output logic [31:0]                     pkt_drop_cnt
);

  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  localparam logic [1:0] ST_SOP  = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        ready_q;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  logic [C_AXIS_DATA_WIDTH-1:0]  data_mem [C_FIFO_DEPTH];
  logic [SW-1:0]                 strb_mem [C_FIFO_DEPTH];
  logic [C_AXIS_TUSER_WIDTH-1:0] user_mem [C_FIFO_DEPTH];
  logic                          last_mem [C_FIFO_DEPTH];

  logic fifo_full, fifo_empty;
  logic match, accept, wr_en, rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign match = |(s_axis_tuser[31:24] & C_PORT_MASK);

  // ready_q holds tready low until the first edge after reset release.
  // A non-matching first beat can always be swallowed, even with a full FIFO.
  always_comb begin
    s_axis_tready = 1'b0;
    if (ready_q) begin
      case (state_q)
        ST_DROP: s_axis_tready = 1'b1;
        ST_FWD:  s_axis_tready = ~fifo_full;
        default: s_axis_tready = ~fifo_full | ~match;
      endcase
    end
  end

  assign accept = s_axis_tvalid & s_axis_tready;
  assign wr_en  = accept & ~fifo_full &
                  ((state_q == ST_FWD) | ((state_q == ST_SOP) & match));
  assign rd_en  = ~fifo_empty & m_axis_tready;

  assign wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  // Packet-level state: the first beat decides forward or drop for the rest.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SOP: begin
        if (accept && !s_axis_tlast) begin
          state_d = match ? ST_FWD : ST_DROP;
        end
      end
      ST_FWD, ST_DROP: begin
        if (accept && s_axis_tlast) begin
          state_d = ST_SOP;
        end
      end
      default: state_d = ST_SOP;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q  <= ST_SOP;
      ready_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= 1'b1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array needs no reset; validity is tracked by the pointers.
  always_ff @(posedge axi_aclk) begin
    if (wr_en) begin
      data_mem[wr_ptr_q[AW-1:0]] <= s_axis_tdata;
      strb_mem[wr_ptr_q[AW-1:0]] <= s_axis_tstrb;
      user_mem[wr_ptr_q[AW-1:0]] <= s_axis_tuser;
      last_mem[wr_ptr_q[AW-1:0]] <= s_axis_tlast;
    end
  end

  // Head of the FIFO is presented directly; it only moves on a pop, so the
  // payload holds steady while the consumer stalls.
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = data_mem[rd_ptr_q[AW-1:0]];
  assign m_axis_tstrb  = strb_mem[rd_ptr_q[AW-1:0]];
  assign m_axis_tuser  = user_mem[rd_ptr_q[AW-1:0]];
  assign m_axis_tlast  = last_mem[rd_ptr_q[AW-1:0]];

`ifdef NF10_TX_FILTER_STATS_EN
  logic [31:0] fwd_cnt_q, drop_cnt_q;

  // A packet is counted when its tlast beat is taken; wr_en tells which way.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      fwd_cnt_q  <= 32'h0;
      drop_cnt_q <= 32'h0;
    end else if (accept && s_axis_tlast) begin
      if (wr_en) begin
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
      end else begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign pkt_fwd_cnt  = fwd_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;
`else
  assign pkt_fwd_cnt  = 32'h0;
  assign pkt_drop_cnt = 32'h0;
`endif

endmodule

// File: doc/nf10_axis_port_tx_filter.md
NF10_AXIS_PORT_TX_FILTER -- requirements
Module: nf10_axis_port_tx_filter

Interface
REQ-001 Parameter C_AXIS_DATA_WIDTH, default 256, SHALL set the tdata width of both streams; tstrb width SHALL be C_AXIS_DATA_WIDTH/8.
REQ-002 Parameter C_AXIS_TUSER_WIDTH, default 128, SHALL set the tuser width of both streams.
REQ-003 Parameter C_PORT_MASK, default 8'h04, SHALL give the one-hot destination-port bit served by this instance.
REQ-004 Parameter C_FIFO_DEPTH, default 16, power of two, SHALL set the output FIFO depth in beats.
REQ-005 axi_aclk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-006 axi_resetn  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 s_axis_tdata/tstrb/tuser/tvalid/tlast  in  per REQ-001/002  SHALL carry the switch-side packet stream; s_axis_tready  out  1.
REQ-008 m_axis_tdata/tstrb/tuser/tvalid/tlast  out  per REQ-001/002  SHALL feed the 10G interface slave port; m_axis_tready  in  1.
REQ-009 pkt_fwd_cnt  out  32  SHALL count forwarded packets; pkt_drop_cnt  out  32  SHALL count dropped packets.

Function
REQ-010 tuser SHALL be decoded as [15:0] byte length, [23:16] source port, [31:24] destination port; higher bits SHALL pass through unchanged.
REQ-011 The FSM SHALL have states SOP, FWD and DROP.
REQ-012 In SOP, an accepted beat with (tuser[31:24] & C_PORT_MASK) != 0 SHALL be written to the FIFO; the FSM SHALL then go to FWD if tlast=0 or stay in SOP if tlast=1.
REQ-013 In SOP, an accepted beat with no match SHALL be discarded; the FSM SHALL then go to DROP if tlast=0 or stay in SOP if tlast=1.
REQ-014 In FWD, every accepted beat SHALL be written to the FIFO; an accepted tlast beat SHALL return the FSM to SOP.
REQ-015 In DROP, every accepted beat SHALL be discarded; an accepted tlast beat SHALL return the FSM to SOP.
REQ-016 s_axis_tready SHALL be 1 in DROP, !fifo_full in FWD, and (!fifo_full | no-match) in SOP.
REQ-017 A write while full SHALL be blocked even if a read occurs in the same cycle; no beat SHALL ever be lost or duplicated.
REQ-018 The FIFO SHALL store tdata, tstrb, tuser and tlast; m_axis_tvalid SHALL equal !fifo_empty.
REQ-019 Latency from s_axis beat acceptance to m_axis_tvalid SHALL be exactly 1 cycle when the FIFO is empty.
REQ-020 m_axis payload SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 The FIFO pointers SHALL be log2(C_FIFO_DEPTH)+1 bits wide and wrap modulo 2*C_FIFO_DEPTH; full when the MSBs differ and the low bits are equal.
REQ-022 The counters SHALL increment by 1 on acceptance of a packet's tlast beat (forward or drop) and SHALL wrap from 32'hFFFFFFFF to 0.

Reset
REQ-023 On axi_resetn=0, asynchronously: FSM=SOP, FIFO empty, m_axis_tvalid=0, counters=0, s_axis_tready=0.
REQ-024 s_axis_tready SHALL stay 0 in the first cycle after reset release.
REQ-025 Reset mid-packet SHALL discard the FIFO contents and the partial packet; the first post-reset beat SHALL be treated as SOP.

Configuration
REQ-026 With macro NF10_TX_FILTER_STATS_EN defined, pkt_fwd_cnt and pkt_drop_cnt SHALL operate per REQ-022.
REQ-027 Without NF10_TX_FILTER_STATS_EN, both counter ports SHALL remain present, tied to 32'h0, and no counter registers SHALL be synthesised.

Verification
REQ-028 Three-beat packet with tuser[31:24]=8'h04, m_axis_tready=1 -> three beats out in order, first one cycle after acceptance, tlast on beat 3, pkt_fwd_cnt=1.
REQ-029 Two-beat packet with tuser[31:24]=8'h01 -> s_axis_tready=1 on both beats, no m_axis_tvalid, pkt_drop_cnt=1.
REQ-030 m_axis_tready=0, 20 matching single-beat packets -> exactly 16 accepted and s_axis_tready=0 at full; a non-matching SOP beat is still accepted and dropped.
REQ-031 Back-to-back single-beat packets match/no-match/match -> two beats out, counters fwd=2 and drop=1, FSM in SOP after each.
REQ-032 axi_resetn pulsed low after beat 2 of a 4-beat forwarded packet -> m_axis_tvalid=0 immediately, counters=0, next packet forwarded intact.
REQ-033 Build without NF10_TX_FILTER_STATS_EN -> traffic per REQ-028 gives identical m_axis output and both counters read 0.
